// File: rtl/cmem_arbiter.sv
// Serialises CPU fetch (a) and data (b) cmem ports onto one pmem port; responds to both together.
// Latency: IDLE -> pmem request next cycle; cmem_resp one cycle after the last pmem_resp.
// Backpressure: cmem requests are held until resp; pmem requests are held until pmem_resp.
module cmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmem_read_a,
  input  logic [ADDR_W-1:0]   cmem_address_a,
  output logic                cmem_resp_a,
  output logic [DATA_W-1:0]   cmem_rdata_a,
  input  logic                cmem_read_b,
  input  logic                cmem_write_b,
  input  logic [DATA_W/8-1:0] cmem_byte_enable_b,
  input  logic [ADDR_W-1:0]   cmem_address_b,
  input  logic [DATA_W-1:0]   cmem_wdata_b,
  output logic                cmem_resp_b,
  output logic [DATA_W-1:0]   cmem_rdata_b,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_byte_enable,
  input  logic                pmem_resp,
  input  logic [DATA_W-1:0]   pmem_rdata
);

  typedef enum logic [1:0] {IDLE, MEM_A, MEM_B, RESP} state_t;

  state_t              state, state_n;
  logic                pend_a, pend_b, done_a, done_b;
  logic                pend_a_n, pend_b_n, done_a_n, done_b_n;
  logic                lat_a, lat_b, cap_a, cap_b;
  logic [ADDR_W-1:0]   la_addr;
  logic                lb_read, lb_write;
  logic [ADDR_W-1:0]   lb_addr;
  logic [DATA_W-1:0]   lb_wdata;
  logic [DATA_W/8-1:0] lb_be;
  logic [DATA_W-1:0]   buf_a, buf_b;
  logic                req_b, match_a, match_b, all_match;
  logic                mem_a, mem_b_rd, mem_b_wr;

  assign req_b = cmem_read_b | cmem_write_b;

  // A port matches when it is not pending or its live request equals what was latched.
  // Write data and enables only matter for writes.
  assign match_a = !pend_a || (cmem_read_a && (cmem_address_a == la_addr));
  assign match_b = !pend_b ||
                   ((cmem_read_b == lb_read) && (cmem_write_b == lb_write) &&
                    (cmem_address_b == lb_addr) &&
                    (!cmem_write_b || ((cmem_wdata_b == lb_wdata) && (cmem_byte_enable_b == lb_be))));
  assign all_match = match_a && match_b;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state, flag updates and latch/capture strobes.
  always_comb begin
    state_n  = state;
    pend_a_n = pend_a;
    pend_b_n = pend_b;
    done_a_n = done_a;
    done_b_n = done_b;
    lat_a    = 1'b0;
    lat_b    = 1'b0;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    case (state)
      IDLE: begin
        if (cmem_read_a || req_b) begin
          lat_a    = cmem_read_a;
          lat_b    = req_b;
          pend_a_n = cmem_read_a;
          pend_b_n = req_b;
          done_a_n = 1'b0;
          done_b_n = 1'b0;
          state_n  = req_b ? MEM_B : MEM_A;
        end
      end
      MEM_A: begin
        if (pmem_resp) begin
          cap_a    = 1'b1;
          done_a_n = 1'b1;
          state_n  = (pend_b && !done_b) ? MEM_B : RESP;
        end
      end
      MEM_B: begin
        if (pmem_resp) begin
          cap_b    = 1'b1;
          done_b_n = 1'b1;
          state_n  = (pend_a && !done_a) ? MEM_A : RESP;
        end
      end
      RESP: begin
        if (all_match) begin
          state_n = IDLE;
        end else begin
          // A changed request is re-served; a withdrawn one is dropped.
          if (!match_a) begin
            if (cmem_read_a) begin
              lat_a    = 1'b1;
              done_a_n = 1'b0;
            end else begin
              pend_a_n = 1'b0;
            end
          end
          if (!match_b) begin
            if (req_b) begin
              lat_b    = 1'b1;
              done_b_n = 1'b0;
            end else begin
              pend_b_n = 1'b0;
            end
          end
          if (pend_b_n && !done_b_n)      state_n = MEM_B;
          else if (pend_a_n && !done_a_n) state_n = MEM_A;
          else if (pend_a_n || pend_b_n)  state_n = RESP;
          else                            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Flags, request latches and read buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      la_addr  <= '0;
      lb_read  <= 1'b0;
      lb_write <= 1'b0;
      lb_addr  <= '0;
      lb_wdata <= '0;
      lb_be    <= '0;
      buf_a    <= '0;
      buf_b    <= '0;
    end else begin
      pend_a <= pend_a_n;
      pend_b <= pend_b_n;
      done_a <= done_a_n;
      done_b <= done_b_n;
      if (lat_a) la_addr <= cmem_address_a;
      if (lat_b) begin
        lb_read  <= cmem_read_b;
        lb_write <= cmem_write_b;
        lb_addr  <= cmem_address_b;
        lb_wdata <= cmem_wdata_b;
        lb_be    <= cmem_byte_enable_b;
      end
      if (cap_a) buf_a <= pmem_rdata;
      if (cap_b) buf_b <= pmem_rdata;
    end
  end

  assign mem_a    = (state == MEM_A);
  assign mem_b_rd = (state == MEM_B) && lb_read;
  assign mem_b_wr = (state == MEM_B) && lb_write;

  // pmem is driven only from latched values, so it stays stable for the whole transaction.
  always_comb begin
    pmem_read        = mem_a || mem_b_rd;
    pmem_write       = mem_b_wr;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = '0;
    if (mem_a) begin
      pmem_address     = la_addr;
      pmem_byte_enable = '1;
    end else if (mem_b_rd || mem_b_wr) begin
      pmem_address     = lb_addr;
      pmem_byte_enable = mem_b_wr ? lb_be : '1;
      pmem_wdata       = mem_b_wr ? lb_wdata : '0;
    end
  end

  assign cmem_resp_a  = (state == RESP) && all_match && pend_a;
  assign cmem_resp_b  = (state == RESP) && all_match && pend_b;
  assign cmem_rdata_a = buf_a;
  assign cmem_rdata_b = buf_b;

endmodule
